// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with registered
// coordinates, data-enable, sync and line/frame start pulses.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_check
        $fatal(1, "video_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          h_wrap;
    logic          de_nxt;
    logic          hs_act;
    logic          vs_act;

    // Outputs are decoded from the next count so they align with pos_x/pos_y.
    always_comb begin
        h_wrap = (x_cnt == H_LAST);
        x_nxt  = h_wrap ? '0 : x_cnt + CW'(1);
        y_nxt  = y_cnt;
        if (h_wrap) begin
            y_nxt = (y_cnt == V_LAST) ? '0 : y_cnt + CW'(1);
        end
        de_nxt = (x_nxt < H_ACT) && (y_nxt < V_ACT);
        hs_act = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
        vs_act = (y_nxt >= VS_BEG) && (y_nxt < VS_END);
    end

    // Counters start on the last pixel so the first advance lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt       <= H_LAST;
            y_cnt       <= V_LAST;
            pos_x       <= '0;
            pos_y       <= '0;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            x_cnt       <= x_nxt;
            y_cnt       <= y_nxt;
            pos_x       <= x_nxt;
            pos_y       <= y_nxt;
            de          <= de_nxt;
            hsync       <= SYNC_POL ? hs_act : ~hs_act;
            vsync       <= SYNC_POL ? vs_act : ~vs_act;
            line_start  <= (x_nxt == '0);
            frame_start <= (x_nxt == '0) && (y_nxt == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: 640x480 instance plus a tiny active-high
// instance, checked every cycle against an advance-count raster model.
module tb_video_timing_gen;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [11:0] a_x, a_y, b_x, b_y;
    logic        a_de, a_hs, a_vs, a_ls, a_fs;
    logic        b_de, b_hs, b_vs, b_ls, b_fs;

    int checks   = 0;
    int failures = 0;

    longint n_adv = 0;
    bit     adv   = 1'b0;

    video_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .pos_x(a_x), .pos_y(a_y), .de(a_de),
        .hsync(a_hs), .vsync(a_vs),
        .line_start(a_ls), .frame_start(a_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CW(12)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .pos_x(b_x), .pos_y(b_y), .de(b_de),
        .hsync(b_hs), .vsync(b_vs),
        .line_start(b_ls), .frame_start(b_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Raster position is simply (advances-1) modulo the frame size.
    function automatic logic [28:0] model(
        input longint n, input bit a,
        input int ht, input int ha, input int hfp, input int hsw,
        input int vt, input int va, input int vfp, input int vsw,
        input bit pol);
        longint p;
        int     x, y;
        bit     d, h, v, ls, fs;
        if (n == 0) return {12'd0, 12'd0, 1'b0, ~pol, ~pol, 2'b00};
        p  = (n - 1) % (ht * vt);
        x  = int'(p % ht);
        y  = int'(p / ht);
        d  = (x < ha) && (y < va);
        h  = (x >= ha + hfp) && (x < ha + hfp + hsw);
        v  = (y >= va + vfp) && (y < va + vfp + vsw);
        ls = a && (x == 0);
        fs = a && (p == 0);
        return {12'(x), 12'(y), d, pol ? h : ~h, pol ? v : ~v, ls, fs};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_adv <= 0;
            adv   <= 1'b0;
        end else if (ce) begin
            n_adv <= n_adv + 1;
            adv   <= 1'b1;
        end else begin
            adv   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("model_a", {3'b0, a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs},
              {3'b0, model(n_adv, adv, 800, 640, 16, 96, 525, 480, 10, 2, 1'b0)});
        check("model_b", {3'b0, b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs},
              {3'b0, model(n_adv, adv, 14, 8, 2, 2, 7, 4, 1, 1, 1'b1)});
    end

    task automatic cyc(input logic c);
        ce = c;
        @(posedge clk);
        #1;
    endtask

    int          de_cnt, hs_low, first_blank, ls_per, fs_per;
    int          fs_cnt, vs_cnt;
    logic [15:0] hmask;
    logic [7:0]  vmask;
    bit          ok;

    initial begin
        rst_n = 1'b1;
        ce    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_pos", {a_x, a_y}, 24'h000000);
        check("rst_a_sig", {a_de, a_hs, a_vs, a_ls, a_fs}, 5'b01100);
        check("rst_b_sync", {b_hs, b_vs}, 2'b00);

        rst_n = 1'b1;
        cyc(1'b1);
        check("first_a", {a_x, a_y, a_de, a_ls, a_fs}, {24'h0, 3'b111});
        check("first_b_fs", b_fs, 1'b1);

        de_cnt = 0; hs_low = 0; first_blank = -1; ls_per = 0;
        fs_per = 0; fs_cnt = 0; vs_cnt = 0; hmask = '0; vmask = '0;
        for (int i = 0; i < 980; i++) begin
            if (i > 0) cyc(1'b1);
            if (a_y == 12'd0) begin
                de_cnt += int'(a_de);
                if (!a_hs) hs_low++;
                if (!a_de && first_blank < 0) first_blank = int'(a_x);
            end
            if (a_ls && i > 0 && ls_per == 0) ls_per = i;
            if (b_fs) begin
                fs_cnt++;
                if (i > 0 && fs_per == 0) fs_per = i;
            end
            if (b_vs) begin
                vs_cnt++;
                vmask[b_y[2:0]] = 1'b1;
            end
            if (b_hs) hmask[b_x[3:0]] = 1'b1;
        end
        check("line0_de_cnt", de_cnt, 640);
        check("line0_first_blank", first_blank, 640);
        check("line0_hs_low", hs_low, 96);
        check("line_period", ls_per, 800);
        check("b_frame_period", fs_per, 98);
        check("b_frame_cnt", fs_cnt, 10);
        check("b_vs_cycles", vs_cnt, 140);
        check("b_hs_cols", hmask, 16'h0C00);
        check("b_vs_rows", vmask, 8'h20);

        for (int i = 0; i < 40; i++) cyc((i % 3) != 1);

        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (b_x == 12'd13 && b_y == 12'd6) ok = 1'b1;
            else cyc(1'b1);
        end
        check("b_reach_wrap", ok, 1'b1);
        cyc(1'b1);
        check("b_wrap", {b_x, b_y, b_fs}, {24'h0, 1'b1});
        repeat (3) cyc(1'b0);
        check("b_hold", {b_x, b_y, b_de, b_fs}, {24'h0, 2'b10});

        ok = 1'b0;
        for (int i = 0; i < 900 && !ok; i++) begin
            if (a_x == 12'd300) ok = 1'b1;
            else cyc(1'b1);
        end
        check("a_reach_300", ok, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_a_pos", {a_x, a_y}, 24'h000000);
        check("async_a_sig", {a_de, a_hs, a_vs, a_ls, a_fs}, 5'b01100);
        check("async_b_sig", {b_de, b_hs, b_vs, b_fs}, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1);
        check("restart_a", {a_x, a_y, a_de, a_fs}, {24'h0, 2'b11});
        repeat (30) cyc(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
